// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port (CPU/DMA) arbiter onto a single-port data memory, 3-state IDLE/ACCESS/ACK FSM.
// Define DATA_MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_nx;
  logic gnt, gnt_nx, elig0, elig1, l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif
  // the port being acked cannot re-issue in its own ack cycle
  always_comb begin
    elig0 = req0 && (state == IDLE || (state == ACK && gnt));
    elig1 = req1 && (state == IDLE || (state == ACK && !gnt));
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    gnt_nx = !elig0;
`else
    gnt_nx = (elig0 && elig1) ? !last_grant : !elig0;
`endif
    state_nx = (state == ACCESS) ? ACK : (elig0 || elig1) ? ACCESS : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_nx;
      if (elig0 || elig1) begin
        gnt <= gnt_nx;
        l_we <= gnt_nx ? we1 : we0;
        l_addr <= gnt_nx ? addr1 : addr0;
        l_wdata <= gnt_nx ? wdata1 : wdata0;
      end
      if (state == ACCESS && !l_we && !gnt) rdata0 <= mem_dout;
      if (state == ACCESS && !l_we && gnt) rdata1 <= mem_dout;
    end
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= 1'b1;
    else if (elig0 || elig1) last_grant <= gnt_nx;
`endif
  assign mem_addr = (state == ACCESS) ? l_addr : '0;
  assign mem_din = (state == ACCESS) ? l_wdata : '0;
  assign mem_wen = (state == ACCESS) && l_we;
  assign mem_ren = (state == ACCESS) && !l_we;
  assign ack0 = (state == ACK) && !gnt;
  assign ack1 = (state == ACK) && gnt;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: vector table, corner sequences and a randomized run against a grant-timeline model.
module tb_data_mem_arbiter;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic rq [2], wq [2];
  logic [9:0] aq [2];
  logic [31:0] dq [2];
  logic ack0, ack1, mem_wen, mem_ren, busy;
  logic [31:0] rdata0, rdata1, mem_din, mem_dout;
  logic [9:0] mem_addr;
  logic [31:0] mem [1024];
  logic pre_en = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
    .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_dout(mem_dout), .busy(busy)
  );
  assign mem_dout = mem[mem_addr];
  always @(posedge clk)
    if (mem_wen) mem[mem_addr] <= mem_din;
    else if (pre_en) mem[pre_addr] <= pre_data;
  wire [127:0] obs = {17'b0, ack0, ack1, mem_wen, mem_ren, busy, mem_addr, mem_din, rdata0, rdata1};
  // ctl = {ack0, ack1, wen, ren, busy}
  function automatic logic [127:0] ep(logic [4:0] c, logic [9:0] a, logic [31:0] d, logic [31:0] r0, logic [31:0] r1);
    return {17'b0, c, a, d, r0, r1};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask
  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0;
      wq[p] = 1'b0;
      aq[p] = '0;
      dq[p] = '0;
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask
  typedef struct {
    logic [1:0] r;
    logic [1:0] w;
    logic [9:0] a0, a1;
    logic [31:0] d0;
    logic [4:0] ctl;
    logic [9:0] ea;
    logic [31:0] ed, e0, e1;
  } vec_t;
  vec_t tbl [15];
  localparam logic [31:0] V1 = 32'h11111111, V2 = 32'h22222222, CB = 32'hCAFEBABE;
  initial begin
    logic [10:1] ackv, wenv;
    logic [31:0] rmem [16];
    logic [31:0] erd [2];
    logic pend [2];
    logic acc_we, e0, e1;
    logic [9:0] acc_addr;
    logic [31:0] acc_data, v;
    int n, g, g1, g2, ml;
    // both ports reading 1/2 from reset, then port 0 alone writes and reads 15
    tbl[0]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b00011, 10'd1, 32'd0, 32'd0, 32'd0};
    tbl[1]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b10001, 10'd0, 32'd0, V1, 32'd0};
    tbl[2]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b00011, 10'd2, 32'd0, V1, 32'd0};
    tbl[3]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b01001, 10'd0, 32'd0, V1, V2};
    tbl[4]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b00011, 10'd1, 32'd0, V1, V2};
    tbl[5]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b10001, 10'd0, 32'd0, V1, V2};
    tbl[6]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b00011, 10'd2, 32'd0, V1, V2};
    tbl[7]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'd0, 5'b01001, 10'd0, 32'd0, V1, V2};
    tbl[8]  = '{2'b00, 2'b00, 10'd1, 10'd2, 32'd0, 5'b00000, 10'd0, 32'd0, V1, V2};
    tbl[9]  = '{2'b01, 2'b01, 10'd15, 10'd0, CB, 5'b00101, 10'd15, CB, V1, V2};
    tbl[10] = '{2'b01, 2'b01, 10'd15, 10'd0, CB, 5'b10001, 10'd0, 32'd0, V1, V2};
    tbl[11] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 5'b00000, 10'd0, 32'd0, V1, V2};
    tbl[12] = '{2'b01, 2'b00, 10'd15, 10'd0, 32'd0, 5'b00011, 10'd15, 32'd0, V1, V2};
    tbl[13] = '{2'b01, 2'b00, 10'd15, 10'd0, 32'd0, 5'b10001, 10'd0, 32'd0, CB, V2};
    tbl[14] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 5'b00000, 10'd0, 32'd0, CB, V2};
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 chk("reset_state", obs, 128'd0);
    @(negedge clk) reset_n = 1'b1;
    preload(10'd1, V1);
    preload(10'd2, V2);
    for (int i = 0; i < 15; i++) begin
      rq[0] = tbl[i].r[0];
      rq[1] = tbl[i].r[1];
      wq[0] = tbl[i].w[0];
      wq[1] = tbl[i].w[1];
      aq[0] = tbl[i].a0;
      aq[1] = tbl[i].a1;
      dq[0] = tbl[i].d0;
      dq[1] = '0;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), obs, ep(tbl[i].ctl, tbl[i].ea, tbl[i].ed, tbl[i].e0, tbl[i].e1));
    end
    // req0 withdrawn during ACCESS: the read still completes and acks
    preload(10'd100, 32'h12345678);
    rq[0] = 1'b1;
    wq[0] = 1'b0;
    aq[0] = 10'd100;
    @(posedge clk);
    #1 chk("drop_access", obs, ep(5'b00011, 10'd100, 32'd0, CB, V2));
    rq[0] = 1'b0;
    @(posedge clk);
    #1 chk("drop_ack", obs, ep(5'b10001, 10'd0, 32'd0, 32'h12345678, V2));
    @(posedge clk);
    #1 chk("drop_idle", obs, ep(5'b00000, 10'd0, 32'd0, 32'h12345678, V2));
    // port 1 alone, three back-to-back writes
    rq[1] = 1'b1;
    wq[1] = 1'b1;
    aq[1] = 10'd20;
    dq[1] = 32'hA0000000;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1 ackv[c] = ack1;
      wenv[c] = mem_wen;
      if (ack1) begin
        n++;
        aq[1] = 10'(20 + n);
        dq[1] = 32'hA0000000 + 32'(n);
        if (n == 3) rq[1] = 1'b0;
      end
    end
    chk("solo_ack_spacing", 128'(ackv), 128'(10'b0010010010));
    chk("solo_wen_spacing", 128'(wenv), 128'(10'b0001001001));
    for (int i = 0; i < 3; i++) chk($sformatf("solo_mem%0d", i), 128'(mem[20 + i]), 128'(32'hA0000000 + 32'(i)));
    idle_inputs();
    // reset asserted mid-ACCESS of a write
    preload(10'd5, 32'h5A5A5A5A);
    rq[0] = 1'b1;
    wq[0] = 1'b1;
    aq[0] = 10'd5;
    dq[0] = 32'hDEADBEEF;
    @(posedge clk);
    #1 chk("abort_access", obs, ep(5'b00101, 10'd5, 32'hDEADBEEF, 32'h12345678, V2));
    #2 reset_n = 1'b0;
    #1 chk("abort_async", obs, 128'd0);
    rq[0] = 1'b0;
    @(posedge clk);
    #1 chk("abort_hold", obs, 128'd0);
    chk("abort_mem", 128'(mem[5]), 128'(32'h5A5A5A5A));
    @(negedge clk) reset_n = 1'b1;
    // randomized traffic against a grant-timeline model
    idle_inputs();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      preload(10'(i), v);
      rmem[i] = v;
    end
    g1 = -1;
    g2 = -1;
    ml = 1;
    erd[0] = '0;
    erd[1] = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    acc_we = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (g1 >= 0) begin
        if (acc_we) rmem[acc_addr[3:0]] = acc_data;
        else erd[g1] = rmem[acc_addr[3:0]];
      end
      e0 = rq[0] && g1 < 0 && g2 != 0;
      e1 = rq[1] && g1 < 0 && g2 != 1;
      g = (e0 && e1) ? (FIXED ? 0 : 1 - ml) : e0 ? 0 : e1 ? 1 : -1;
      if (g >= 0) begin
        ml = g;
        acc_we = wq[g];
        acc_addr = aq[g];
        acc_data = dq[g];
      end
      chk($sformatf("rand%0d", k), obs, ep({g1 == 0, g1 == 1, g >= 0 && acc_we, g >= 0 && !acc_we, g >= 0 || g1 >= 0},
          g >= 0 ? acc_addr : 10'd0, g >= 0 ? acc_data : 32'd0, erd[0], erd[1]));
      g2 = g1;
      g1 = g;
      for (int p = 0; p < 2; p++)
        if (pend[p] && (p == 0 ? ack0 : ack1)) begin
          pend[p] = 1'b0;
          rq[p] = 1'b0;
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          rq[p] = 1'b1;
          wq[p] = 1'($urandom);
          aq[p] = 10'($urandom_range(0, 15));
          dq[p] = $urandom;
        end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from port 0 (CPU) and port 1 (DMA).
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read, per port.
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W  word address, per port.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data, per port.
REQ-009 The block SHALL have ports ack0/ack1  output  1  one-cycle access-complete pulse, per port.
REQ-010 The block SHALL have ports rdata0/rdata1  output  DATA_W  registered read data, per port.
REQ-011 The block SHALL have ports mem_addr/mem_din  output  ADDR_W/DATA_W  memory address and write data.
REQ-012 The block SHALL have ports mem_wen/mem_ren  output  1  memory write and read enables.
REQ-013 The block SHALL have port mem_dout  input  DATA_W  combinational memory read data.
REQ-014 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS and ACK.
REQ-016 In IDLE or ACK, when an eligible request exists at posedge, the FSM SHALL latch that port's we/addr/wdata and go to ACCESS; otherwise it SHALL go to IDLE.
REQ-017 ACCESS SHALL last exactly one cycle: mem_addr/mem_din driven from latched registers, mem_wen = latched we, mem_ren = !latched we; all mem_* outputs SHALL be 0 outside ACCESS.
REQ-018 At the posedge ending ACCESS, a read SHALL capture mem_dout into rdata of the granted port, and the FSM SHALL go to ACK.
REQ-019 In ACK, the granted port's ack SHALL be 1 for exactly one cycle; the other port's ack SHALL be 0.
REQ-020 Latency SHALL be fixed: req sampled at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2.
REQ-021 Requesters hold req/we/addr/wdata stable until ack and drop req at the edge ending the ack cycle.
REQ-022 In ACK, the just-acked port SHALL be ineligible for arbitration in that cycle, so a single port issues at most one access per 3 cycles.
REQ-023 Two ports alternating SHALL sustain one access per 2 cycles (ACK -> ACCESS directly).
REQ-024 When both ports are eligible, round-robin SHALL grant the port not granted last; last_grant SHALL update on each grant.
REQ-025 If req drops while in ACCESS, the access SHALL still complete and ack SHALL still pulse.
REQ-026 rdataN SHALL hold its value until the next read completes for port N; writes SHALL NOT change rdata.

Reset
REQ-027 reset_n low SHALL immediately force state = IDLE, ack0 = ack1 = 0, mem_wen = mem_ren = 0, mem_addr = mem_din = 0, rdata0 = rdata1 = 0, busy = 0, and last_grant = 1, so port 0 wins the first tie.
REQ-028 An access in flight when reset asserts SHALL be aborted with no memory write and no ack.

Configuration
REQ-029 With macro DATA_MEM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win when both ports are eligible, and last_grant SHALL be unused.
REQ-030 Without DATA_MEM_ARB_FIXED_PRIO_EN, round-robin per REQ-024 SHALL apply.

Verification
REQ-031 Scenario: reset_n low mid-ACCESS with a port-0 write to addr 5 of 0xDEADBEEF -> all outputs 0 asynchronously, mem[5] unchanged, no ack0.
REQ-032 Scenario: port 0 writes 0xCAFEBABE to addr 15, then reads addr 15 -> ack0 at N+2 for each access, rdata0 = 0xCAFEBABE, mem_wen high exactly one cycle.
REQ-033 Scenario: req0 and req1 both held for reads of addr 1 and addr 2, pre-loaded with 0x11111111 and 0x22222222 -> grants alternate 0,1,0,1, acks spaced 2 cycles apart, rdata values correct.
REQ-034 Scenario: req1 held alone for 3 back-to-back writes -> acks 3 cycles apart, never two consecutive ACCESS cycles for port 1.
REQ-035 Scenario: with DATA_MEM_ARB_FIXED_PRIO_EN defined, both ports continuously requesting -> port 1 is granted only in cycles where port 0 is ineligible per REQ-022.
REQ-036 Scenario: req0 drops in the ACCESS cycle of a read of addr 100 holding 0x12345678 -> ack0 still pulses and rdata0 = 0x12345678.
